// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline memory clients, the arbiter and the
// shared backing memory. Port-indexed vectors are flattened with port p at
// [p*W +: W]. The arbiter uses the slave modport; clients plus memory model
// use the master modport.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Client side
  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*3-1:0]          funct3_i;
  logic [NUM_PORTS-1:0]            abort_i;
  logic [NUM_PORTS-1:0]            ready_o;
  logic [DATA_WIDTH-1:0]           rdata_o;
  logic [NUM_PORTS-1:0]            grant_o;

  // Backing memory side
  logic                            mem_req_o;
  logic                            mem_we_o;
  logic [ADDR_WIDTH-1:0]           mem_addr_o;
  logic [DATA_WIDTH-1:0]           mem_wdata_o;
  logic [2:0]                      mem_funct3_o;
  logic                            mem_ack_i;
  logic [DATA_WIDTH-1:0]           mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, funct3_i, abort_i,
    input  mem_ack_i, mem_rdata_i,
    output ready_o, rdata_o, grant_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, funct3_i, abort_i,
    output mem_ack_i, mem_rdata_i,
    input  ready_o, rdata_o, grant_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between N pipeline memory clients and one shared
// backing memory.
//
// Handshake: a client raises req_i[p] and holds it, with its we/addr/wdata/
// funct3, until it sees ready_o[p] (a one-cycle pulse) or it aborts. The
// arbiter raises mem_req_o and holds it, with stable mem_* fields, until the
// memory returns a one-cycle mem_ack_i (mem_rdata_i valid alongside it).
// abort_i[p] keeps p from being granted while it waits; once p is in service
// the memory access still completes, but p gets no ready_o and rdata_o is
// left alone.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  mem_port_arbiter_if.slave bus,
  output logic              dbg_state_o   // 1 while BUSY
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state;
  logic [PW-1:0]         last_grant;
  logic                  abort_q;

  logic [NUM_PORTS-1:0]  eligible;
  logic                  pick_valid;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         cand;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [2:0]            sel_funct3;
  logic                  cur_abort;

  assign eligible    = bus.req_i & ~bus.abort_i;
  // An abort seen this cycle or at any earlier BUSY cycle cancels the reply.
  assign cur_abort   = abort_q | (|(bus.abort_i & bus.grant_o));
  assign dbg_state_o = (state == BUSY);

  // Round-robin search starting just after the last served port.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Mux the chosen port's request fields out of the flattened buses.
  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_funct3 = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PW'(p) == pick_idx) begin
        sel_we     = bus.we_i[p];
        sel_addr   = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata  = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        sel_funct3 = bus.funct3_i[p*3 +: 3];
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      last_grant       <= PW'(NUM_PORTS - 1);
      abort_q          <= 1'b0;
      bus.ready_o      <= '0;
      bus.rdata_o      <= '0;
      bus.grant_o      <= '0;
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
      bus.mem_funct3_o <= '0;
    end else begin
      bus.ready_o <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.grant_o      <= NUM_PORTS'(1) << pick_idx;
            bus.mem_req_o    <= 1'b1;
            bus.mem_we_o     <= sel_we;
            bus.mem_addr_o   <= sel_addr;
            bus.mem_wdata_o  <= sel_wdata;
            bus.mem_funct3_o <= sel_funct3;
            abort_q          <= 1'b0;
            state            <= BUSY;
          end
        end
        BUSY: begin
          if (cur_abort) begin
            abort_q <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (bus.grant_o[p]) begin
                last_grant <= PW'(p);
              end
            end
            if (!cur_abort) begin
              bus.ready_o <= bus.grant_o;
              if (!bus.mem_we_o) begin
                bus.rdata_o <= bus.mem_rdata_i;
              end
            end
            bus.grant_o   <= '0;
            bus.mem_req_o <= 1'b0;
            abort_q       <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-port instance for most scenarios
// and a 4-port instance for the wrap-around round-robin case. Inputs change
// and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic dbg2, dbg4;
  int   errors = 0;
  int   checks = 0;

  // Clock
  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if #(.NUM_PORTS(2)) bus2 ();
  mem_port_arbiter_if #(.NUM_PORTS(4)) bus4 ();

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bus         (bus2.slave),
    .dbg_state_o (dbg2)
  );

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut4 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bus         (bus4.slave),
    .dbg_state_o (dbg4)
  );

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic init_inputs();
    bus2.req_i = '0; bus2.we_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0;
    bus2.funct3_i = '0; bus2.abort_i = '0; bus2.mem_ack_i = 1'b0; bus2.mem_rdata_i = '0;
    bus4.req_i = '0; bus4.we_i = '0; bus4.addr_i = '0; bus4.wdata_i = '0;
    bus4.funct3_i = '0; bus4.abort_i = '0; bus4.mem_ack_i = 1'b0; bus4.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Memory responder for the 2-port bus: wait for mem_req_o, check who is
  // granted and what address is presented, ack for one cycle, check ready_o.
  task automatic mem_serve2(input string name, input logic [1:0] exp_grant,
                            input logic [31:0] exp_addr, input logic [31:0] rd,
                            input logic [1:0] exp_ready);
    int waited = 0;
    @(negedge clk_i);
    while (!bus2.mem_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checks++;
    if (bus2.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: mem_req_o=%b expected 1 within 20 cycles", name, bus2.mem_req_o);
      return;
    end
    checks++;
    if (bus2.grant_o !== exp_grant) begin
      errors++;
      $display("FAIL %s_grant: got %b expected %b", name, bus2.grant_o, exp_grant);
    end
    checks++;
    if (bus2.mem_addr_o !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: got %h expected %h", name, bus2.mem_addr_o, exp_addr);
    end
    bus2.mem_ack_i = 1'b1;
    bus2.mem_rdata_i = rd;
    @(negedge clk_i);
    bus2.mem_ack_i = 1'b0;
    bus2.mem_rdata_i = '0;
    checks++;
    if (bus2.ready_o !== exp_ready) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, bus2.ready_o, exp_ready);
    end
    checks++;
    if (bus2.grant_o !== 2'b00 || bus2.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: grant_o=%b mem_req_o=%b expected 00 and 0", name,
               bus2.grant_o, bus2.mem_req_o);
    end
  endtask

  // Same responder for the 4-port bus.
  task automatic mem_serve4(input string name, input logic [3:0] exp_grant,
                            input logic [31:0] exp_addr, input logic [3:0] exp_ready);
    int waited = 0;
    @(negedge clk_i);
    while (!bus4.mem_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checks++;
    if (bus4.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: mem_req_o=%b expected 1 within 20 cycles", name, bus4.mem_req_o);
      return;
    end
    checks++;
    if (bus4.grant_o !== exp_grant) begin
      errors++;
      $display("FAIL %s_grant: got %b expected %b", name, bus4.grant_o, exp_grant);
    end
    checks++;
    if (bus4.mem_addr_o !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: got %h expected %h", name, bus4.mem_addr_o, exp_addr);
    end
    bus4.mem_ack_i = 1'b1;
    @(negedge clk_i);
    bus4.mem_ack_i = 1'b0;
    checks++;
    if (bus4.ready_o !== exp_ready) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, bus4.ready_o, exp_ready);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    do_reset();
    checks++;
    if (bus2.grant_o !== 2'b00 || bus2.ready_o !== 2'b00 || bus2.mem_req_o !== 1'b0 ||
        bus2.mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl2: grant=%b ready=%b req=%b we=%b expected all 0",
               bus2.grant_o, bus2.ready_o, bus2.mem_req_o, bus2.mem_we_o);
    end
    checks++;
    if (bus2.rdata_o !== 32'h0 || bus2.mem_addr_o !== 32'h0 || bus2.mem_wdata_o !== 32'h0 ||
        bus2.mem_funct3_o !== 3'h0) begin
      errors++;
      $display("FAIL reset_data2: rdata=%h addr=%h wdata=%h funct3=%h expected all 0",
               bus2.rdata_o, bus2.mem_addr_o, bus2.mem_wdata_o, bus2.mem_funct3_o);
    end
    checks++;
    if (bus4.grant_o !== 4'b0000 || bus4.mem_req_o !== 1'b0 || dbg2 !== 1'b0 || dbg4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl4: grant4=%b req4=%b dbg2=%b dbg4=%b expected all 0",
               bus4.grant_o, bus4.mem_req_o, dbg2, dbg4);
    end
  endtask

  task automatic test_single_read();
    bus2.req_i = 2'b01;
    bus2.we_i = 2'b00;
    bus2.addr_i[0 +: 32] = 32'h100;
    bus2.funct3_i[0 +: 3] = 3'b010;
    @(negedge clk_i);
    checks++;
    if (bus2.mem_req_o !== 1'b1 || bus2.grant_o !== 2'b01) begin
      errors++;
      $display("FAIL read_grant: req=%b grant=%b expected 1 and 01", bus2.mem_req_o, bus2.grant_o);
    end
    checks++;
    if (bus2.mem_addr_o !== 32'h100 || bus2.mem_we_o !== 1'b0 || bus2.mem_funct3_o !== 3'b010) begin
      errors++;
      $display("FAIL read_fields: addr=%h we=%b funct3=%b expected 00000100 0 010",
               bus2.mem_addr_o, bus2.mem_we_o, bus2.mem_funct3_o);
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (bus2.mem_req_o !== 1'b1 || bus2.ready_o !== 2'b00 || dbg2 !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: req=%b ready=%b dbg=%b expected 1 00 1",
               bus2.mem_req_o, bus2.ready_o, dbg2);
    end
    bus2.mem_ack_i = 1'b1;
    bus2.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    bus2.mem_ack_i = 1'b0;
    bus2.mem_rdata_i = '0;
    bus2.req_i = 2'b00;
    checks++;
    if (bus2.ready_o !== 2'b01 || bus2.rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_done: ready=%b rdata=%h expected 01 deadbeef", bus2.ready_o, bus2.rdata_o);
    end
    checks++;
    if (bus2.grant_o !== 2'b00 || bus2.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL read_release: grant=%b req=%b expected 00 0", bus2.grant_o, bus2.mem_req_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus2.ready_o !== 2'b00 || bus2.rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_pulse: ready=%b rdata=%h expected 00 deadbeef", bus2.ready_o, bus2.rdata_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    bus2.req_i = 2'b11;
    bus2.we_i = 2'b00;
    bus2.addr_i[0 +: 32] = 32'h400;
    bus2.addr_i[32 +: 32] = 32'h800;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      mem_serve2($sformatf("rr%0d", k), exp, (k % 2 == 0) ? 32'h400 : 32'h800,
                 32'h1000 + k, exp);
      checks++;
      if (bus2.rdata_o !== 32'h1000 + k) begin
        errors++;
        $display("FAIL rr%0d_rdata: got %h expected %h", k, bus2.rdata_o, 32'h1000 + k);
      end
    end
    bus2.req_i = 2'b00;
    @(negedge clk_i);
    checks++;
    if (bus2.grant_o !== 2'b00 || dbg2 !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: grant=%b dbg=%b expected 00 0", bus2.grant_o, dbg2);
    end
  endtask

  task automatic test_four_port_wrap();
    do_reset();
    bus4.addr_i[32 +: 32] = 32'h40;
    bus4.addr_i[96 +: 32] = 32'hC0;
    bus4.req_i = 4'b0010;
    mem_serve4("p4_first", 4'b0010, 32'h40, 4'b0010);
    bus4.req_i = 4'b1010;
    mem_serve4("p4_wrap", 4'b1000, 32'hC0, 4'b1000);
    mem_serve4("p4_back", 4'b0010, 32'h40, 4'b0010);
    bus4.req_i = 4'b0000;
  endtask

  task automatic test_abort_busy();
    bus2.req_i = 2'b01;
    bus2.we_i = 2'b00;
    bus2.addr_i[0 +: 32] = 32'h10;
    mem_serve2("pre_abort", 2'b01, 32'h10, 32'hCAFEF00D, 2'b01);
    bus2.req_i = 2'b10;
    bus2.we_i = 2'b10;
    bus2.addr_i[32 +: 32] = 32'h200;
    bus2.wdata_i[32 +: 32] = 32'h55;
    @(negedge clk_i);
    checks++;
    if (bus2.grant_o !== 2'b10 || bus2.mem_we_o !== 1'b1 || bus2.mem_addr_o !== 32'h200 ||
        bus2.mem_wdata_o !== 32'h55) begin
      errors++;
      $display("FAIL abort_issue: grant=%b we=%b addr=%h wdata=%h expected 10 1 00000200 00000055",
               bus2.grant_o, bus2.mem_we_o, bus2.mem_addr_o, bus2.mem_wdata_o);
    end
    bus2.abort_i = 2'b10;
    @(negedge clk_i);
    bus2.abort_i = 2'b00;
    checks++;
    if (bus2.mem_req_o !== 1'b1 || bus2.mem_addr_o !== 32'h200 || bus2.mem_we_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_mem_kept: req=%b addr=%h we=%b expected 1 00000200 1",
               bus2.mem_req_o, bus2.mem_addr_o, bus2.mem_we_o);
    end
    @(negedge clk_i);
    bus2.mem_ack_i = 1'b1;
    bus2.mem_rdata_i = 32'hBAD0BAD0;
    bus2.req_i = 2'b00;
    bus2.we_i = 2'b00;
    @(negedge clk_i);
    bus2.mem_ack_i = 1'b0;
    bus2.mem_rdata_i = '0;
    checks++;
    if (bus2.ready_o !== 2'b00 || bus2.rdata_o !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL abort_suppress: ready=%b rdata=%h expected 00 cafef00d", bus2.ready_o, bus2.rdata_o);
    end
    checks++;
    if (bus2.grant_o !== 2'b00 || bus2.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: grant=%b req=%b expected 00 0", bus2.grant_o, bus2.mem_req_o);
    end
  endtask

  task automatic test_abort_idle();
    // Port 1 was served last, so port 0 would win if not aborted.
    bus2.req_i = 2'b11;
    bus2.abort_i = 2'b01;
    bus2.addr_i[32 +: 32] = 32'h204;
    mem_serve2("abort_idle", 2'b10, 32'h204, 32'h0A0A0A0A, 2'b10);
    bus2.req_i = 2'b00;
    bus2.abort_i = 2'b00;
    checks++;
    if (bus2.rdata_o !== 32'h0A0A0A0A) begin
      errors++;
      $display("FAIL abort_idle_rdata: got %h expected 0a0a0a0a", bus2.rdata_o);
    end
  endtask

  task automatic test_reset_busy();
    bus2.req_i = 2'b01;
    bus2.addr_i[0 +: 32] = 32'h500;
    @(negedge clk_i);
    checks++;
    if (bus2.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rstb_start: mem_req_o=%b expected 1", bus2.mem_req_o);
    end
    rst_n_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus2.mem_req_o !== 1'b0 || bus2.grant_o !== 2'b00 || bus2.rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rstb_drop: req=%b grant=%b rdata=%h expected 0 00 0",
               bus2.mem_req_o, bus2.grant_o, bus2.rdata_o);
    end
    rst_n_i = 1'b1;
    bus2.req_i = 2'b11;
    bus2.mem_ack_i = 1'b1;
    bus2.mem_rdata_i = 32'h77;
    @(negedge clk_i);
    bus2.mem_ack_i = 1'b0;
    bus2.mem_rdata_i = '0;
    checks++;
    if (bus2.ready_o !== 2'b00 || bus2.rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rstb_late_ack: ready=%b rdata=%h expected 00 0", bus2.ready_o, bus2.rdata_o);
    end
    checks++;
    if (bus2.grant_o !== 2'b01 || bus2.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rstb_first: grant=%b req=%b expected 01 1", bus2.grant_o, bus2.mem_req_o);
    end
    mem_serve2("rstb_serve", 2'b01, 32'h500, 32'h99, 2'b01);
    bus2.req_i = 2'b00;
  endtask

  task automatic test_read_then_write();
    bus2.req_i = 2'b01;
    bus2.we_i = 2'b00;
    bus2.addr_i[0 +: 32] = 32'h300;
    mem_serve2("rw_read", 2'b01, 32'h300, 32'h12345678, 2'b01);
    bus2.we_i = 2'b01;
    bus2.wdata_i[0 +: 32] = 32'hA5A5A5A5;
    mem_serve2("rw_write", 2'b01, 32'h300, 32'hFFFFFFFF, 2'b01);
    bus2.req_i = 2'b00;
    bus2.we_i = 2'b00;
    checks++;
    if (bus2.rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL rw_rdata_hold: got %h expected 12345678", bus2.rdata_o);
    end
    checks++;
    if (bus2.mem_we_o !== 1'b1 || bus2.mem_wdata_o !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rw_wfields: we=%b wdata=%h expected 1 a5a5a5a5", bus2.mem_we_o, bus2.mem_wdata_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus2.ready_o !== 2'b00 || bus2.rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL rw_after: ready=%b rdata=%h expected 00 12345678", bus2.ready_o, bus2.rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_four_port_wrap();
    test_abort_busy();
    test_abort_idle();
    test_reset_busy();
    test_read_then_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
